// File: rtl/lockstep_compare.sv
// Lockstep equivalence checker: CHANNELS x WIDTH buses, side A delayed SKEW cycles, error
// counting, first-failure capture, optional halt. Define LOCKSTEP_MASK_EN to add chan_mask.
module lockstep_compare #(
   parameter int WIDTH       = 1,
   parameter int CHANNELS    = 2,
   parameter int SKEW        = 0,
   parameter int CNT_W       = 8,
   parameter int HALT_ON_ERR = 0
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            en,
   input  logic                                            clear,
   input  logic [CHANNELS*WIDTH-1:0]                       side_a,
   input  logic [CHANNELS*WIDTH-1:0]                       side_b,
`ifdef LOCKSTEP_MASK_EN
   input  logic [CHANNELS-1:0]                             chan_mask,
`endif
   output logic [CHANNELS-1:0]                             mismatch,
   output logic                                            err_sticky,
   output logic [CNT_W-1:0]                                err_count,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_ch,
   output logic [CNT_W-1:0]                                first_cyc,
   output logic [1:0]                                      state_o
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [3:0] FILL_LAST = (SKEW > 0) ? 4'(SKEW - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_CHECK = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t                    state, state_nx;
   logic [3:0]                fill_cnt, fill_nx;
   logic [CNT_W-1:0]          cyc_cnt;
   logic [CHANNELS*WIDTH-1:0] a_dly;
   logic                      vld_dly;
   logic [CHANNELS-1:0]       active;
   logic [CHANNELS-1:0]       diff;
   logic                      do_cmp;
   logic                      hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [CH_W-1:0] lowest_idx(input logic [CHANNELS-1:0] v);
      lowest_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = CH_W'(i);
      end
   endfunction

`ifdef LOCKSTEP_MASK_EN
   assign active = ~chan_mask;
`else
   assign active = '1;
`endif

   // Stage boundary: side A and its valid bit are delayed to line up with side B
   generate
      if (SKEW == 0) begin : g_nodly
         assign a_dly   = side_a;
         assign vld_dly = en;
      end else begin : g_dly
         logic [CHANNELS*WIDTH-1:0] a_p [SKEW];
         logic [SKEW-1:0]           vld_p;
         logic                      flush;

         assign flush = (state == S_FILL) && !en;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < SKEW; i++) a_p[i] <= '0;
               vld_p <= '0;
            end else begin
               a_p[0] <= side_a;
               for (int i = 1; i < SKEW; i++) a_p[i] <= a_p[i-1];
               if (clear || flush) begin
                  vld_p <= '0;
               end else begin
                  vld_p[0] <= en;
                  for (int i = 1; i < SKEW; i++) vld_p[i] <= vld_p[i-1];
               end
            end
         end

         assign a_dly   = a_p[SKEW-1];
         assign vld_dly = vld_p[SKEW-1];
      end
   endgenerate

   always_comb begin
      diff = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         diff[i] = (a_dly[i*WIDTH +: WIDTH] != side_b[i*WIDTH +: WIDTH]) && active[i];
      end
   end

   // A clear on the same edge discards any compare result
   assign do_cmp = (state == S_CHECK) && en && vld_dly && !clear;
   assign hit    = do_cmp && (|diff);

   always_comb begin
      state_nx = state;
      fill_nx  = fill_cnt;
      case (state)
         S_IDLE: begin
            if (en) begin
               state_nx = (SKEW > 0) ? S_FILL : S_CHECK;
               fill_nx  = '0;
            end
         end
         S_FILL: begin
            if (!en)                        state_nx = S_IDLE;
            else if (fill_cnt == FILL_LAST) state_nx = S_CHECK;
            else                            fill_nx  = fill_cnt + 4'd1;
         end
         S_CHECK: begin
            if (!en)                              state_nx = S_IDLE;
            else if (hit && (HALT_ON_ERR != 0))   state_nx = S_HALT;
         end
         default: state_nx = state;
      endcase
      if (clear) state_nx = S_IDLE;
   end

   // Stage boundary: compare results and status registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         fill_cnt   <= '0;
         cyc_cnt    <= '0;
         mismatch   <= '0;
         err_sticky <= 1'b0;
         err_count  <= '0;
         first_ch   <= '0;
         first_cyc  <= '0;
      end else begin
         state    <= state_nx;
         fill_cnt <= fill_nx;
         if (clear) begin
            cyc_cnt    <= '0;
            mismatch   <= '0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            first_ch   <= '0;
            first_cyc  <= '0;
         end else begin
            mismatch <= do_cmp ? diff : '0;
            if (hit) begin
               err_count <= sat_inc(err_count);
               if (!err_sticky) begin
                  err_sticky <= 1'b1;
                  first_ch   <= lowest_idx(diff);
                  first_cyc  <= cyc_cnt;
               end
            end
            if (state == S_CHECK) begin
               if (!en)         cyc_cnt <= '0;
               else if (do_cmp) cyc_cnt <= sat_inc(cyc_cnt);
            end else if (state != S_HALT) begin
               cyc_cnt <= '0;
            end
         end
      end
   end

   assign state_o = state;

endmodule

// File: doc/lockstep_compare.md
Name: lockstep_compare

Overview:
- Parametrised, clocked equivalence checker for comparing two implementations in lockstep, for simulation and formal.
- Generalises the single-bit o1 == o2 check to CHANNELS buses of WIDTH bits, with a programmable latency skew between the two sides.
- Adds error counting, first-failure capture and an optional halt-on-error mode.
- Instantiated beside two candidate designs in a verification top; its outputs feed assertions and cover properties.

Parameters:
- WIDTH, 1, bits per channel.
- CHANNELS, 2, number of compared channels.
- SKEW, 0, cycles by which side B lags side A (0..15); side A is delayed SKEW cycles before comparison.
- CNT_W, 8, width of the error and cycle counters.
- HALT_ON_ERR, 0, when 1 the checker freezes in HALT after the first mismatch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  comparison enable.
- clear  in  1  synchronous clear of all status and return to IDLE.
- side_a  in  CHANNELS*WIDTH  outputs of implementation A; channel i at bits [i*WIDTH +: WIDTH].
- side_b  in  CHANNELS*WIDTH  outputs of implementation B; same packing.
- mismatch  out  CHANNELS  per-channel mismatch flags, registered, one per compared cycle.
- err_sticky  out  1  set on first mismatch; held until clear or reset.
- err_count  out  CNT_W  number of cycles with any mismatch; saturating.
- first_ch  out  $clog2(CHANNELS)  (min 1 bit)  lowest-index failing channel of the first failing cycle.
- first_cyc  out  CNT_W  cycle index, within CHECK, of the first failure.
- state_o  out  2  current state: IDLE=0, FILL=1, CHECK=2, HALT=3.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 and the state goes to IDLE.
  - The delay line and its valid bits are cleared.
  - The same applies when reset is asserted mid-operation.
- Delay line:
  - side_a and a valid bit (equal to en) shift through SKEW stages every cycle.
  - With SKEW=0 the path is a direct wire.
- IDLE:
  - The cycle counter is held at 0.
  - en=1 moves to FILL if SKEW>0, otherwise directly to CHECK.
- FILL:
  - Counts SKEW consecutive cycles with en=1, then moves to CHECK.
  - en=0 returns to IDLE and flushes the valid bits.
- CHECK:
  - Compares every cycle in which en=1 and the delayed valid bit is 1: channel i mismatches when delayed_a[i] != side_b[i].
  - mismatch is registered and appears 1 cycle after the sampled edge. All bits are 0 on cycles where no compare happens.
  - The cycle counter increments each compared cycle and saturates at 2^CNT_W-1.
  - en=0 returns to IDLE. Status (sticky, count, first capture) is retained; the cycle counter resets.
- On any mismatch in a compared cycle:
  - err_count increments, saturating at 2^CNT_W-1 and never wrapping.
  - If err_sticky was 0: set err_sticky, capture first_ch (lowest failing index) and first_cyc (cycle counter value at that compare).
  - Later mismatches never overwrite first_ch or first_cyc.
- HALT (entered only when HALT_ON_ERR=1, on the cycle after the first mismatch):
  - No further compares; mismatch stays 0.
  - err_count, first_ch and first_cyc are frozen.
  - Exit only via clear or reset.
- clear=1:
  - Next state is IDLE; all status outputs and the delay-line valid bits are zeroed.
  - clear has priority over a simultaneous mismatch, which is discarded.
  - clear together with en=1 still lands in IDLE; FILL starts on the following cycle.
- Multi-channel failure in one cycle: err_count increments by exactly 1.

Optional Feature:
- LOCKSTEP_MASK_EN defined:
  - Adds input chan_mask (CHANNELS bits). A set bit excludes that channel from comparison: its mismatch bit is forced to 0 and it cannot affect count, sticky or first capture.
  - chan_mask is sampled on the same edge as the data.
- LOCKSTEP_MASK_EN undefined: the port is absent and all channels are always compared.

Test Plan:
1. CHANNELS=2, WIDTH=4, SKEW=0: drive identical random data with en=1 for 100 cycles -> mismatch=0, err_sticky=0, err_count=0 throughout.
2. SKEW=3, side_b = side_a delayed 3 cycles: en=1 -> state IDLE->FILL (3 cycles)->CHECK, no mismatches. Then flip side_b channel 1 bit 2 on CHECK cycle 5 -> mismatch=2'b10 one cycle later, first_ch=1, first_cyc=5, err_count=1.
3. Both channels differ on the same cycle, then channel 0 differs again 2 cycles later -> first_ch=0, err_count=2, first capture unchanged.
4. HALT_ON_ERR=1, first mismatch at cycle 10 -> state_o=3 from the next cycle; further mismatches leave err_count=1. Pulse clear -> state_o=0, all status 0.
5. CNT_W=4 with a mismatch every cycle for 20 cycles -> err_count saturates at 15. Assert rst=0 mid-run -> all outputs 0 immediately, without waiting for a clock edge.
6. LOCKSTEP_MASK_EN defined, chan_mask=2'b01, channel 0 corrupted -> no mismatch. Then unmask -> mismatch=2'b01 one cycle after the next compare.
